// File: rtl/sram_ctrl.sv
// sram_ctrl: Wishbone classic slave to asynchronous SRAM bridge with
// programmable read/write wait states and a data-hold cycle after writes.
// Ports: wb_clk_i/wb_rst_i (sync active-high reset), Wishbone slave
//   wb_cyc_i/wb_stb_i/wb_we_i/wb_sel_i/wb_adr_i/wb_dat_i/wb_dat_o/wb_ack_o,
//   SRAM pins sram_ce_n/sram_oe_n/sram_we_n/sram_be_n/sram_addr/sram_data.
// Option: define SRAM_CTRL_BYTE_LANES_EN to honour wb_sel_i on sram_be_n.
module sram_ctrl #(
   parameter int ADDRESS_WIDTH = 18,
   parameter int DATA_WIDTH    = 16,
   parameter int READ_WAIT     = 2,
   parameter int WRITE_WAIT    = 2
) (
   input  logic                      wb_clk_i,
   input  logic                      wb_rst_i,
   input  logic                      wb_cyc_i,
   input  logic                      wb_stb_i,
   input  logic                      wb_we_i,
   input  logic [DATA_WIDTH/8-1:0]   wb_sel_i,
   input  logic [ADDRESS_WIDTH-1:0]  wb_adr_i,
   input  logic [DATA_WIDTH-1:0]     wb_dat_i,
   output logic [DATA_WIDTH-1:0]     wb_dat_o,
   output logic                      wb_ack_o,
   output logic                      sram_ce_n,
   output logic                      sram_oe_n,
   output logic                      sram_we_n,
   output logic [DATA_WIDTH/8-1:0]   sram_be_n,
   output logic [ADDRESS_WIDTH-1:0]  sram_addr,
   inout  wire  [DATA_WIDTH-1:0]     sram_data
);

   localparam int NB   = DATA_WIDTH / 8;
   localparam int MAXW = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
   localparam int CW   = (MAXW < 2) ? 1 : $clog2(MAXW + 1);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE,
      ACK
   } state_e;

   state_e                   state_q, state_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0]    wdat_q, wdat_d;
   logic [DATA_WIDTH-1:0]    rdat_q, rdat_d;
   logic                     ack_q, ack_d;
   logic                     ce_n_q, ce_n_d;
   logic                     oe_n_q, oe_n_d;
   logic                     we_n_q, we_n_d;
   logic [NB-1:0]            be_n_q, be_n_d;
   logic                     drv_q, drv_d;
   logic                     abort_q, abort_d;

   // Lane enables applied at acceptance and whether a write strobes WE/CE.
   logic [NB-1:0]            be_acc;
   logic                     wr_en;

`ifdef SRAM_CTRL_BYTE_LANES_EN
   assign be_acc = ~wb_sel_i;
   assign wr_en  = |wb_sel_i;
`else
   logic sel_unused;
   assign sel_unused = ^wb_sel_i;
   assign be_acc     = '0;
   assign wr_en      = 1'b1;
`endif

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdat_q  <= '0;
         rdat_q  <= '0;
         ack_q   <= 1'b0;
         ce_n_q  <= 1'b1;
         oe_n_q  <= 1'b1;
         we_n_q  <= 1'b1;
         be_n_q  <= '1;
         drv_q   <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdat_q  <= wdat_d;
         rdat_q  <= rdat_d;
         ack_q   <= ack_d;
         ce_n_q  <= ce_n_d;
         oe_n_q  <= oe_n_d;
         we_n_q  <= we_n_d;
         be_n_q  <= be_n_d;
         drv_q   <= drv_d;
         abort_q <= abort_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdat_d  = wdat_q;
      rdat_d  = rdat_q;
      ack_d   = 1'b0;
      ce_n_d  = ce_n_q;
      oe_n_d  = oe_n_q;
      we_n_d  = we_n_q;
      be_n_d  = be_n_q;
      drv_d   = drv_q;
      abort_d = abort_q;
      unique case (state_q)
         IDLE: begin
            if (wb_cyc_i && wb_stb_i) begin
               addr_d  = wb_adr_i;
               abort_d = 1'b0;
               if (wb_we_i) begin
                  wdat_d  = wb_dat_i;
                  cnt_d   = CW'(WRITE_WAIT);
                  drv_d   = 1'b1;
                  state_d = WRITE;
                  if (wr_en) begin
                     ce_n_d = 1'b0;
                     we_n_d = 1'b0;
                     be_n_d = be_acc;
                  end
               end else begin
                  cnt_d   = CW'(READ_WAIT);
                  ce_n_d  = 1'b0;
                  oe_n_d  = 1'b0;
                  be_n_d  = be_acc;
                  state_d = READ;
               end
            end
         end
         READ: begin
            if (!wb_cyc_i) abort_d = 1'b1;
            if (cnt_q == '0) begin
               rdat_d  = sram_data;
               ack_d   = wb_cyc_i & ~abort_q;
               ce_n_d  = 1'b1;
               oe_n_d  = 1'b1;
               be_n_d  = '1;
               state_d = ACK;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         WRITE: begin
            if (!wb_cyc_i) abort_d = 1'b1;
            if (cnt_q == '0) begin
               ack_d   = wb_cyc_i & ~abort_q;
               ce_n_d  = 1'b1;
               we_n_d  = 1'b1;
               be_n_d  = '1;
               state_d = ACK;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         ACK: begin
            // Data stays on the bus through this hold cycle, then releases.
            drv_d   = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign wb_dat_o  = rdat_q;
   assign wb_ack_o  = ack_q;
   assign sram_ce_n = ce_n_q;
   assign sram_oe_n = oe_n_q;
   assign sram_we_n = we_n_q;
   assign sram_be_n = be_n_q;
   assign sram_addr = addr_q;
   assign sram_data = drv_q ? wdat_q : {DATA_WIDTH{1'bz}};

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Parametrised Wishbone-slave controller for asynchronous SRAM; successor to the single-cycle SRAM bridge. Converts classic Wishbone single reads/writes into fully registered SRAM cycles with programmable read/write wait states, per-byte lane enables and a guaranteed data-hold cycle after every write. Sits between the system Wishbone interconnect and the board SRAM pins.

## Interface
Parameters:
- ADDRESS_WIDTH, 18, SRAM word-address width
- DATA_WIDTH, 16, data width; multiple of 8
- READ_WAIT, 2, extra cycles with CE/OE asserted before read data is sampled (0..15)
- WRITE_WAIT, 2, extra cycles with WE asserted beyond the first (0..15)

Ports:
- wb_clk_i  in  1  system clock; all logic on rising edge
- wb_rst_i  in  1  reset; one clock, synchronous, active-high
- wb_cyc_i  in  1  Wishbone cycle
- wb_stb_i  in  1  Wishbone strobe
- wb_we_i  in  1  1 = write, 0 = read
- wb_sel_i  in  DATA_WIDTH/8  byte selects
- wb_adr_i  in  ADDRESS_WIDTH  word address
- wb_dat_i  in  DATA_WIDTH  write data
- wb_dat_o  out  DATA_WIDTH  registered read data
- wb_ack_o  out  1  registered single-cycle acknowledge
- sram_ce_n / sram_oe_n / sram_we_n  out  1 each  registered active-low strobes
- sram_be_n  out  DATA_WIDTH/8  registered active-low byte enables (bit 0 = LB, bit 1 = UB)
- sram_addr  out  ADDRESS_WIDTH  registered address
- sram_data  inout  DATA_WIDTH  driven only in WRITE/ACK of a write, else high-Z

## Operation
- FSM states: IDLE, READ, WRITE, ACK. Wait counter width covers max(READ_WAIT, WRITE_WAIT).
- IDLE: on wb_cyc_i & wb_stb_i at an edge, latch address, data, sel and we into output registers; load counter with READ_WAIT or WRITE_WAIT; go to READ or WRITE. Strobes become active in the following cycle.
- READ: ce_n=0, oe_n=0, be_n=~sel. At an edge with counter==0: capture sram_data into wb_dat_o, ack<=1, ce_n/oe_n<=1, go to ACK. Otherwise decrement.
- WRITE: ce_n=0, we_n=0, sram_data driven, be_n=~sel. At counter==0: we_n<=1, ce_n<=1, ack<=1, go to ACK. Keep data driven and address held.
- ACK: wb_ack_o high for exactly this cycle; wb_stb_i ignored; tri-state sram_data; go to IDLE. A new request can be accepted on the edge ending ACK only via IDLE, so back-to-back transfers always have one idle cycle, giving write-to-read bus turnaround.
- Write with wb_sel_i all zero: no we_n pulse, no ce_n; FSM still runs WRITE for WRITE_WAIT+1 cycles and acks.
- wb_cyc_i dropped mid-transfer: SRAM cycle completes with unchanged timing; ack is suppressed (wb_ack_o stays 0); return to IDLE.
- wb_dat_o holds its last captured value until the next read capture.

## Timing
- Request sampled at edge E0. Read: CE/OE low for READ_WAIT+1 cycles (E0..E(READ_WAIT+1)), data sampled at E(READ_WAIT+1), ack high in cycle E(READ_WAIT+1)..E(READ_WAIT+2).
- Write: WE low for WRITE_WAIT+1 cycles; ack in the following cycle, during which address/data are still held (hold >= 1 cycle, WE already high).
- Minimum request-to-request period: READ_WAIT+3 (read) / WRITE_WAIT+3 (write) cycles.
- Reset values: sram_ce_n=sram_oe_n=sram_we_n=1, sram_be_n=all 1, sram_addr=0, sram_data high-Z, wb_ack_o=0, wb_dat_o=0, state IDLE.
- Reset mid-transfer: at the reset edge all strobes go inactive and the bus is released; no ack is issued.

## Configuration
- SRAM_CTRL_BYTE_LANES_EN defined: sram_be_n follows ~wb_sel_i latched at acceptance; all-zero sel behaves as above.
- Undefined: wb_sel_i ignored, sram_be_n held all 0 whenever ce_n=0 (all 1 otherwise), every write pulses WE regardless of sel.

## Test plan
- Read, READ_WAIT=2, adr=0x00123, SRAM model returns 0xBEEF -> OE low 3 cycles, ack one cycle 4 cycles after E0, wb_dat_o=0xBEEF.
- Write, WRITE_WAIT=1, adr=0x3FFFF, dat=0xA55A, sel=2'b10 -> WE low 2 cycles, sram_be_n=2'b01, data driven through ack cycle, model word upper byte=0xA5, lower unchanged.
- Write 0x1111 then immediate read at same address -> one idle cycle between ack and next CE, no cycle where sram_data is driven while OE is low, read returns 0x1111.
- Write with sel=2'b00 (macro defined) -> no WE/CE pulse, ack after WRITE_WAIT+2 cycles, memory unchanged.
- wb_rst_i asserted during second READ cycle -> next cycle all strobes 1, sram_data high-Z, no ack, wb_dat_o=0.
- wb_cyc_i dropped during WRITE -> WE pulse completes at full width, wb_ack_o never asserts, FSM back in IDLE and accepts next request.
